uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter4.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: channel codes, FSM states, channel count.
package uart_pkg;

  localparam int N_CH = 4;

  typedef enum logic [1:0] {
    CH_GAME   = 2'd0,
    CH_MOUSE  = 2'd1,
    CH_GLOVES = 2'd2,
    CH_SCORE  = 2'd3
  } ch_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin: searches from (last+1) mod 4 upward, last itself lowest.
module rr_arbiter4
  import uart_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      gnt,
  output logic            valid
);

  always_comb begin
    gnt   = last;
    valid = |req;
    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    for (int k = N_CH; k >= 1; k--) begin
      if (req[last + 2'(k)]) gnt = last + 2'(k);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Change-driven byte arbiter feeding a UART TX FIFO; one byte per 3 cycles at most.
// Optional periodic full resend of all channels when UART_REFRESH_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_full,
  input  logic [7:0] data_game_state_sel,
  input  logic [7:0] data_mouse_control,
  input  logic [7:0] data_gloves_control,
  input  logic [7:0] data_score_control,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [1:0] grant_ch
);

  logic [7:0]      w_din [N_CH];
  logic [7:0]      r_din [N_CH];
  logic [7:0]      r_last [N_CH];
  logic [N_CH-1:0] r_pend;
  logic [N_CH-1:0] w_pend_next;
  logic [N_CH-1:0] w_clear;
  state_e          r_state;
  state_e          w_state_next;
  ch_e             r_grant;
  logic [7:0]      r_wdata;
  logic [1:0]      w_gnt;
  logic            w_gnt_valid;
  logic            w_take;
  logic            w_refresh;

  assign w_din[0] = data_game_state_sel;
  assign w_din[1] = data_mouse_control;
  assign w_din[2] = data_gloves_control;
  assign w_din[3] = data_score_control;

`ifdef UART_REFRESH_EN
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [CNT_W-1:0] r_refresh_cnt;

  assign w_refresh = (r_refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || w_refresh) r_refresh_cnt <= '0;
    else                  r_refresh_cnt <= r_refresh_cnt + 1'b1;
  end
`else
  assign w_refresh = 1'b0;
`endif

  // The channel being written compares against the byte it is committing, so a
  // change that slipped in after capture re-arms pending without a gap.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [7:0] w_last_eff;
    assign w_clear[gi]     = (r_state == ST_WRITE) && (r_grant == 2'(gi));
    assign w_last_eff      = w_clear[gi] ? r_wdata : r_last[gi];
    assign w_pend_next[gi] = (r_pend[gi] & ~w_clear[gi])
                           | (r_din[gi] != w_last_eff)
                           | w_refresh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_din[i]  <= 8'h00;
        r_last[i] <= 8'h00;
      end
    end else begin
      r_pend <= w_pend_next;
      for (int i = 0; i < N_CH; i++) begin
        r_din[i] <= w_din[i];
        if (w_clear[i]) r_last[i] <= r_wdata;
      end
    end
  end

  rr_arbiter4 u_rr (
    .req   (r_pend),
    .last  (r_grant),
    .gnt   (w_gnt),
    .valid (w_gnt_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    wr_uart      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid && !tx_full) begin
          w_take       = 1'b1;
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_uart      = 1'b1;
        w_state_next = ST_GAP;
      end
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= CH_SCORE;
      r_wdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_grant <= ch_e'(w_gnt);
        r_wdata <= r_din[w_gnt];
      end
    end
  end

  assign w_data   = r_wdata;
  assign grant_ch = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_full;
  logic [7:0] d_game, d_mouse, d_gloves, d_score;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [1:0] grant_ch;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.REFRESH_CYCLES(100)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tx_full             (tx_full),
    .data_game_state_sel (d_game),
    .data_mouse_control  (d_mouse),
    .data_gloves_control (d_gloves),
    .data_score_control  (d_score),
    .wr_uart             (wr_uart),
    .w_data              (w_data),
    .grant_ch            (grant_ch)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; tx_full = 1'b0;
    d_game = 8'h00; d_mouse = 8'h00; d_gloves = 8'h00; d_score = 8'h00;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp += 3;
    if (wr_uart !== 1'b0)   begin n_err++; $display("FAIL reset_wr: got %b expected 0", wr_uart); end
    if (w_data !== 8'h00)   begin n_err++; $display("FAIL reset_wdata: got %h expected 00", w_data); end
    if (grant_ch !== 2'd3)  begin n_err++; $display("FAIL reset_grant: got %0d expected 3", grant_ch); end
    for (int c = 1; c <= 10; c++) begin
      tick;
      n_cmp++;
      if (wr_uart !== 1'b0) begin n_err++; $display("FAIL reset_idle_wr: cycle %0d got %b expected 0", c, wr_uart); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_latency;
    do_reset;
    d_score = 8'hE5;
    for (int c = 1; c <= 12; c++) begin
      tick;
      n_cmp++;
      if (wr_uart !== (c == 3)) begin n_err++; $display("FAIL single_wr: cycle %0d got %b expected %b", c, wr_uart, (c == 3)); end
      if (c == 3 || c == 12) begin
        n_cmp += 2;
        if (w_data !== 8'hE5)  begin n_err++; $display("FAIL single_wdata: cycle %0d got %h expected e5", c, w_data); end
        if (grant_ch !== 2'd3) begin n_err++; $display("FAIL single_grant: cycle %0d got %0d expected 3", c, grant_ch); end
      end
    end
    $display("test_single_latency: byte e5 on ch3");
  endtask

  task automatic test_all_four;
    logic [7:0] exp_d [4];
    int idx = 0;
    exp_d[0] = 8'h01; exp_d[1] = 8'h22; exp_d[2] = 8'h63; exp_d[3] = 8'hE4;
    do_reset;
    d_game = 8'h01; d_mouse = 8'h22; d_gloves = 8'h63; d_score = 8'hE4;
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (wr_uart === 1'b1) begin
        n_cmp += 3;
        if (idx >= 4 || c != 3 * (idx + 1)) begin n_err++; $display("FAIL all4_time: pulse %0d at cycle %0d expected cycle %0d", idx, c, 3 * (idx + 1)); end
        else begin
          if (w_data !== exp_d[idx])  begin n_err++; $display("FAIL all4_wdata: pulse %0d got %h expected %h", idx, w_data, exp_d[idx]); end
          if (grant_ch !== 2'(idx))   begin n_err++; $display("FAIL all4_grant: pulse %0d got %0d expected %0d", idx, grant_ch, idx); end
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4) begin n_err++; $display("FAIL all4_count: got %0d pulses expected 4", idx); end
    $display("test_all_four: %0d pulses", idx);
  endtask

  task automatic test_tx_full;
    int seen = 0;
    do_reset;
    tx_full = 1'b1;
    d_mouse = 8'h55;
    for (int c = 1; c <= 50; c++) begin
      tick;
      if (c == 25) d_mouse = 8'h57;
      n_cmp++;
      if (wr_uart !== 1'b0) begin n_err++; $display("FAIL full_block: cycle %0d got %b expected 0", c, wr_uart); end
    end
    tx_full = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tick;
      if (wr_uart === 1'b1 && seen == 0) begin
        seen = 1;
        n_cmp += 2;
        if (w_data !== 8'h57)  begin n_err++; $display("FAIL full_wdata: got %h expected 57", w_data); end
        if (grant_ch !== 2'd1) begin n_err++; $display("FAIL full_grant: got %0d expected 1", grant_ch); end
      end
    end
    n_cmp++;
    if (seen != 1) begin n_err++; $display("FAIL full_release: got %0d pulses expected 1", seen); end
    for (int c = 1; c <= 8; c++) begin
      tick;
      n_cmp++;
      if (wr_uart !== 1'b0) begin n_err++; $display("FAIL full_dup: cycle %0d got %b expected 0", c, wr_uart); end
    end
    $display("test_tx_full: released, byte 57 on ch1");
  endtask

  task automatic test_full_in_write;
    do_reset;
    d_game = 8'hA0;
    tick; tick; tick;
    tx_full = 1'b1;
    #1;
    n_cmp += 3;
    if (wr_uart !== 1'b1)  begin n_err++; $display("FAIL fiw_wr: got %b expected 1", wr_uart); end
    if (w_data !== 8'hA0)  begin n_err++; $display("FAIL fiw_wdata: got %h expected a0", w_data); end
    if (grant_ch !== 2'd0) begin n_err++; $display("FAIL fiw_grant: got %0d expected 0", grant_ch); end
    tick;
    n_cmp++;
    if (wr_uart !== 1'b0) begin n_err++; $display("FAIL fiw_single: got %b expected 0", wr_uart); end
    tx_full = 1'b0;
    $display("test_full_in_write: strobe kept");
  endtask

  task automatic test_change_in_write;
    int cnt = 0;
    do_reset;
    d_gloves = 8'h63;
    tick; tick; tick;
    n_cmp += 3;
    if (wr_uart !== 1'b1)  begin n_err++; $display("FAIL ciw_first_wr: got %b expected 1", wr_uart); end
    if (w_data !== 8'h63)  begin n_err++; $display("FAIL ciw_first_wdata: got %h expected 63", w_data); end
    if (grant_ch !== 2'd2) begin n_err++; $display("FAIL ciw_first_grant: got %0d expected 2", grant_ch); end
    d_gloves = 8'h6B;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (wr_uart === 1'b1) begin
        cnt++;
        n_cmp += 3;
        if (c != 3)            begin n_err++; $display("FAIL ciw_time: pulse at cycle %0d expected 3", c); end
        if (w_data !== 8'h6B)  begin n_err++; $display("FAIL ciw_wdata: got %h expected 6b", w_data); end
        if (grant_ch !== 2'd2) begin n_err++; $display("FAIL ciw_grant: got %0d expected 2", grant_ch); end
      end
    end
    n_cmp++;
    if (cnt != 1) begin n_err++; $display("FAIL ciw_count: got %0d pulses expected 1", cnt); end
    $display("test_change_in_write: %0d resend", cnt);
  endtask

  task automatic test_reset_in_write;
    logic [7:0] exp_d [2];
    logic [1:0] exp_c [2];
    int idx = 0;
    exp_d[0] = 8'h3C; exp_c[0] = 2'd1;
    exp_d[1] = 8'h99; exp_c[1] = 2'd3;
    do_reset;
    d_score = 8'h99;
    tick; tick; tick; tick;
    d_mouse = 8'h3C;
    tick; tick;
    rst = 1'b1;
    tick;
    n_cmp += 3;
    if (wr_uart !== 1'b0)  begin n_err++; $display("FAIL riw_wr: got %b expected 0", wr_uart); end
    if (w_data !== 8'h00)  begin n_err++; $display("FAIL riw_wdata: got %h expected 00", w_data); end
    if (grant_ch !== 2'd3) begin n_err++; $display("FAIL riw_grant: got %0d expected 3", grant_ch); end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (wr_uart === 1'b1) begin
        n_cmp += 3;
        if (idx >= 2 || c != 3 * (idx + 1)) begin n_err++; $display("FAIL riw_time: pulse %0d at cycle %0d", idx, c); end
        else begin
          if (w_data !== exp_d[idx])   begin n_err++; $display("FAIL riw_wdata: pulse %0d got %h expected %h", idx, w_data, exp_d[idx]); end
          if (grant_ch !== exp_c[idx]) begin n_err++; $display("FAIL riw_grant: pulse %0d got %0d expected %0d", idx, grant_ch, exp_c[idx]); end
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 2) begin n_err++; $display("FAIL riw_count: got %0d pulses expected 2", idx); end
    $display("test_reset_in_write: %0d pulses after reset", idx);
  endtask

  task automatic test_refresh;
    int idx = 0;
`ifdef UART_REFRESH_EN
    int n_exp = 8;
`else
    int n_exp = 0;
`endif
    do_reset;
    for (int c = 1; c <= 215; c++) begin
      tick;
      if (wr_uart === 1'b1) begin
        n_cmp += 3;
        if (idx >= n_exp || c != 100 * (idx / 4 + 1) + 1 + 3 * (idx % 4)) begin
          n_err++; $display("FAIL refresh_time: pulse %0d at cycle %0d", idx, c);
        end
        if (grant_ch !== 2'(idx % 4)) begin n_err++; $display("FAIL refresh_grant: pulse %0d got %0d expected %0d", idx, grant_ch, idx % 4); end
        if (w_data !== 8'h00)         begin n_err++; $display("FAIL refresh_wdata: pulse %0d got %h expected 00", idx, w_data); end
        idx++;
      end
    end
    n_cmp++;
    if (idx != n_exp) begin n_err++; $display("FAIL refresh_count: got %0d pulses expected %0d", idx, n_exp); end
    $display("test_refresh: %0d pulses in 215 cycles", idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_latency;
    test_all_four;
    test_tx_full;
    test_full_in_write;
    test_change_in_write;
    test_reset_in_write;
    test_refresh;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
